// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_pkg
//  Brief    : Shared constants for the pipeline controller: stage indices,
//             hold-source identifiers, the NOP encoding and a width helper.
//  Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  // Pipeline register indices
  localparam int STG_PC   = 0;
  localparam int STG_IFID = 1;
  localparam int STG_IDEX = 2;

  // Hold-request source identifiers
  localparam int HOLD_BUS   = 0;
  localparam int HOLD_FETCH = 1;

  // Canonical RISC-V NOP (addi x0, x0, 0)
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // Bits needed to index n items, never less than one
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_hold_merge.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_hold_merge
//  Brief    : Reduces the hold-request vector to "any hold active" and the
//             deepest stage frozen by any active source.
//  Revision : 1.0 - initial release
// ============================================================================
module ctrl_hold_merge #(
  parameter int                     NUM_HOLD   = 2,
  parameter int                     SW         = 2,
  parameter logic [NUM_HOLD*SW-1:0] HOLD_STAGE = {2'd0, 2'd2}
) (
  input  logic [NUM_HOLD-1:0] hold_req,
  output logic                hold_act,
  output logic [SW-1:0]       hold_depth
);

  // Maximum frozen stage across the active sources
  always_comb begin
    hold_depth = '0;
    hold_act   = |hold_req;
    for (int s = 0; s < NUM_HOLD; s++) begin
      if (hold_req[s] && (HOLD_STAGE[s*SW +: SW] > hold_depth)) begin
        hold_depth = HOLD_STAGE[s*SW +: SW];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_pipe
//  Brief    : Pipeline controller. Merges hold requests and jump redirects
//             into per-stage stall/flush vectors, parks jumps that arrive
//             while their stage is frozen and inserts post-jump bubbles.
//  Revision : 1.0 - initial release
// ============================================================================
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int STAGES        = 3,
  parameter int NUM_HOLD      = 2,
  parameter logic [NUM_HOLD*sel_width(STAGES)-1:0] HOLD_STAGE = {2'd0, 2'd2},
  parameter int JUMP_STAGE    = 2,
  parameter int BUBBLE_CYCLES = 1,
  parameter int ADDR_W        = 32,
  parameter int CNT_W         = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                jump_en_i,
  input  logic [ADDR_W-1:0]   jump_addr_i,
  input  logic [NUM_HOLD-1:0] hold_req_i,
  output logic                jump_en_o,
  output logic [ADDR_W-1:0]   jump_addr_o,
  output logic [STAGES-1:0]   stall_o,
  output logic [STAGES-1:0]   flush_o,
  output logic                hold_flag_o,
  output logic                err_o,
  output logic [CNT_W-1:0]    stall_cnt_o
);

  localparam int SW = sel_width(STAGES);
  localparam int BW = sel_width(BUBBLE_CYCLES + 1);

  logic              w_hold_act;
  logic [SW-1:0]     w_depth;
  logic              w_blocked;
  logic              w_cand_v;
  logic [ADDR_W-1:0] w_cand_addr;
  logic              w_accept;
  logic [STAGES-1:0] w_stall;
  logic [STAGES-1:0] w_flush;
  logic              w_hold_flag;

  logic              r_pend_v;
  logic [ADDR_W-1:0] r_pend_addr;
  logic [BW-1:0]     r_bubble;
  logic              r_err;
  logic [CNT_W-1:0]  r_stall_cnt;

  ctrl_hold_merge #(
    .NUM_HOLD   (NUM_HOLD),
    .SW         (SW),
    .HOLD_STAGE (HOLD_STAGE)
  ) u_hold_merge (
    .hold_req   (hold_req_i),
    .hold_act   (w_hold_act),
    .hold_depth (w_depth)
  );

  // A parked jump always outranks a fresh request; a hold reaching the jump
  // stage prevents the redirect from issuing this cycle.
  assign w_blocked   = w_hold_act && (int'(w_depth) >= JUMP_STAGE);
  assign w_cand_v    = r_pend_v | jump_en_i;
  assign w_cand_addr = r_pend_v ? r_pend_addr : jump_addr_i;
  assign w_accept    = w_cand_v && !w_blocked;

  // Per-stage stall/flush composition; stall dominates flush on a stage
  always_comb begin
    w_stall = '0;
    w_flush = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (w_hold_act && (k <= int'(w_depth))) w_stall[k] = 1'b1;
      if (w_hold_act && (k == int'(w_depth) + 1)) w_flush[k] = 1'b1;
      if ((r_bubble != '0) && !w_accept && (k == STG_IFID)) w_flush[k] = 1'b1;
      if (w_accept) begin
        if ((k >= 1) && (k <= JUMP_STAGE)) w_flush[k] = 1'b1;
        if (k < JUMP_STAGE) w_stall[k] = 1'b0;
      end
    end
    w_flush = w_flush & ~w_stall;
  end

  assign w_hold_flag = |w_stall;

  // Pending jump, error flag, bubble counter and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_v    <= 1'b0;
      r_pend_addr <= '0;
      r_bubble    <= '0;
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_pend_v <= 1'b0;
      end else if (w_blocked && jump_en_i && !r_pend_v) begin
        r_pend_v    <= 1'b1;
        r_pend_addr <= jump_addr_i;
      end

      if (r_pend_v && jump_en_i) r_err <= 1'b1;

      if (w_accept) begin
        r_bubble <= BW'(BUBBLE_CYCLES);
      end else if ((r_bubble != '0) && !w_stall[STG_IFID]) begin
        r_bubble <= r_bubble - BW'(1);
      end

      if (w_hold_flag && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  // Every output reads zero while reset is asserted
  assign jump_en_o   = rst ? 1'b0 : w_accept;
  assign jump_addr_o = rst ? '0 : (w_accept ? w_cand_addr : jump_addr_i);
  assign stall_o     = rst ? '0 : w_stall;
  assign flush_o     = rst ? '0 : w_flush;
  assign hold_flag_o = rst ? 1'b0 : w_hold_flag;
  assign err_o       = rst ? 1'b0 : r_err;
  assign stall_cnt_o = rst ? '0 : r_stall_cnt;

endmodule
`default_nettype wire

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Parametrised pipeline controller for the RISC-V core.
- Merges N hold-request sources and the branch/jump redirect into per-stage stall and flush vectors, plus the PC redirect.
- Adds two capabilities:
  - parks a jump that arrives while its own stage is stalled, and issues it later;
  - inserts configurable post-jump fetch bubbles for synchronous instruction memory.
- Sits between the EX/bus/mul-div units and the pc_reg, if_id and id_ex pipeline registers.

Parameters:
- STAGES, 3: pipeline register count; stage 0 = PC, 1 = IF/ID, 2 = ID/EX.
- NUM_HOLD, 2: number of hold-request sources.
- HOLD_STAGE, {2'd0,2'd2}: packed NUM_HOLD x SW field (SW = $clog2(STAGES)); the deepest stage each source freezes. Default: src0 = stage 2 (bus/mul), src1 = stage 0 (fetch wait).
- JUMP_STAGE, 2: stage holding the instruction that resolves jumps.
- BUBBLE_CYCLES, 1: extra cycles stage 1 is flushed after an accepted jump (0 = none).
- ADDR_W, 32: address width.
- CNT_W, 32: stall counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- jump_en_i  in  1  single-cycle jump request from JUMP_STAGE
- jump_addr_i  in  ADDR_W  jump target
- hold_req_i  in  NUM_HOLD  level hold requests
- jump_en_o  out  1  PC loads jump_addr_o this cycle
- jump_addr_o  out  ADDR_W  redirect target
- stall_o  out  STAGES  stage k keeps its register
- flush_o  out  STAGES  stage k loads NOP/bubble
- hold_flag_o  out  1  |stall_o (legacy)
- err_o  out  1  sticky: jump lost while another pending
- stall_cnt_o  out  CNT_W  cycles with hold_flag_o=1, saturating

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high.
- Reset:
  - While rst=1, all outputs read 0.
  - At the clock edge, pend_v, pend_addr, bubble_cnt, err_o and stall_cnt_o clear to 0.
  - Reset mid-pending discards the parked jump.
- Hold depth:
  - H = max HOLD_STAGE[s] over active sources; hold_act = |hold_req_i.
  - If hold_act: stall_o[k] = 1 for k <= H.
  - flush_o[H+1] = 1 when H+1 < STAGES (bubble behind the frozen stage).
- Jump candidate:
  - pend_v ? pend_addr : jump_addr_i, valid when pend_v | jump_en_i.
- Accept:
  - A jump is accepted when the candidate is valid and !(hold_act && H >= JUMP_STAGE).
  - Accepted cycle, combinational (0 latency):
    - jump_en_o = 1 and jump_addr_o = candidate;
    - flush_o[k] = 1 for 1 <= k <= JUMP_STAGE;
    - stall_o[k] = 0 for k < JUMP_STAGE (jump overrides shallow holds; sources keep their level and are re-evaluated next cycle).
  - pend_v clears at the edge; bubble_cnt loads BUBBLE_CYCLES.
- Block:
  - A jump_en_i that arrives while hold_act && H >= JUMP_STAGE and pend_v = 0 is parked at the edge: pend_v <= 1, pend_addr <= jump_addr_i.
  - jump_en_o stays 0 while blocked.
- Pending priority:
  - When pend_v = 1, the parked address has priority over a new jump_en_i.
  - A jump_en_i in the same cycle as pend_v sets err_o and is dropped.
  - err_o is cleared only by rst.
- Bubble counter:
  - While bubble_cnt > 0 and no new accept, flush_o[1] = 1 and bubble_cnt decrements each cycle.
  - Flush asserted together with stall on the same stage: stall wins.
  - Bubble decrement is suspended while stall_o[1] = 1.
  - A new accept restarts bubble_cnt at BUBBLE_CYCLES.
- Idle: jump_en_o = 0; jump_addr_o = jump_addr_i (don't-care).
- stall_cnt_o increments on every cycle with hold_flag_o = 1 and saturates at all-ones.

Decomposition:
- Shared package ctrl_pkg:
  - stage index localparams: STG_PC = 0, STG_IFID = 1, STG_IDEX = 2;
  - hold source IDs: HOLD_BUS, HOLD_FETCH;
  - NOP instruction constant 32'h0000_0013.
- Sub-module ctrl_hold_merge: combinational NUM_HOLD -> H / hold_act priority reduction.
- Pending register, bubble counter and stall counter stay in ctrl_pipe.

Test Plan:
- No holds; jump_en_i = 1 with addr 0x0000_0100 for 1 cycle -> same cycle jump_en_o = 1, jump_addr_o = 0x100, flush_o = 3'b110; next cycle flush_o = 3'b010 (BUBBLE_CYCLES = 1); then 3'b000.
- hold_req_i = 2'b01 (stage 2) for 3 cycles, jump_en_i pulsed with 0x200 in cycle 1:
  - cycles 1-3: stall_o = 3'b111, jump_en_o = 0;
  - cycle 4: jump_en_o = 1, addr 0x200, err_o = 0.
- Pending 0x200 parked, second jump_en_i 0x300 while held -> err_o = 1 sticky; on release, jump_addr_o = 0x200 only.
- hold_req_i = 2'b10 (stage 0) with jump 0x400 -> jump_en_o = 1, stall_o = 3'b000, flush_o = 3'b110.
- No jump: hold_req_i = 2'b10 -> stall_o = 3'b001, flush_o = 3'b010; stall_cnt_o counts 5 after 5 cycles; force the counter to all-ones -1, then 2 held cycles -> stays all-ones.
- rst = 1 for 1 cycle while pend_v = 1 and bubble_cnt = 1 -> all outputs 0; after release no jump is issued, stall_cnt_o = 0, err_o = 0.
